// File: rtl/data_send_burst.sv
`default_nettype none
// ============================================================================
// Module   : data_send_burst
// Purpose  : Drains a burst of FIFO words on a trigger and feeds them to a UART
//            TX byte by byte, LSB first, pacing on txBusy.
// Revision : 1.0 - initial release
// ============================================================================
module data_send_burst #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 32,
  parameter int USED_W    = 10,
  parameter int THRESH    = 512,
  parameter int RD_LAT    = 1,
  parameter int GUARD     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              full,
  input  logic              empty,
  input  logic [USED_W-1:0] usedw,
  input  logic [DATA_W-1:0] iData,
  input  logic              txBusy,
  output logic              oRdclk,
  output logic              oNewData,
  output logic [7:0]        oData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int GRD_W = $clog2(GUARD + 1);

  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BURST_LEN - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(BYTES - 1);
  localparam logic [1:0]        LAST_LAT  = 2'(RD_LAT - 1);
  localparam logic [GRD_W-1:0]  LAST_GRD  = GRD_W'(GUARD - 1);
  localparam logic [USED_W:0]   THRESH_V  = (USED_W + 1)'(THRESH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_LAT    = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_GUARD  = 3'd5;
  localparam logic [2:0] S_WAITTX = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic [2:0]        byte_cnt;
  logic [1:0]        lat_cnt;
  logic [GRD_W-1:0]  grd_cnt;
  logic [DATA_W-1:0] shreg;
  logic              trig;
  logic              rdclk_nxt, newdata_nxt, busy_nxt, done_nxt, err_nxt;

  always_comb begin
    trig = 1'b0;
    case (mode)
      2'd0:    trig = full;
      2'd1:    trig = ({1'b0, usedw} >= THRESH_V);
      2'd2:    trig = start;
      default: trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (trig) state_nxt = S_RD;
      S_RD:     state_nxt = empty ? S_DONE : S_LAT;
      // The registered read strobe is high during the first LAT cycle, so LAT
      // spans RD_LAT cycles and LOAD samples exactly RD_LAT cycles after it.
      S_LAT:    if (lat_cnt == LAST_LAT) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SEND;
      S_SEND:   state_nxt = S_GUARD;
      S_GUARD:  if (grd_cnt == LAST_GRD) state_nxt = S_WAITTX;
      S_WAITTX: begin
        if (!txBusy) begin
          if (byte_cnt < LAST_BYTE)      state_nxt = S_SEND;
          else if (word_cnt < LAST_WORD) state_nxt = S_RD;
          else                           state_nxt = S_DONE;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdclk_nxt   = (state == S_RD) && !empty;
    newdata_nxt = (state == S_SEND);
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state_nxt == S_DONE);
    err_nxt     = oErr;
    if (state == S_IDLE && trig)      err_nxt = 1'b0;
    else if (state == S_RD && empty)  err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      lat_cnt  <= '0;
      grd_cnt  <= '0;
      shreg    <= '0;
      oRdclk   <= 1'b0;
      oNewData <= 1'b0;
      oData    <= 8'd0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oRdclk   <= rdclk_nxt;
      oNewData <= newdata_nxt;
      oBusy    <= busy_nxt;
      oDone    <= done_nxt;
      oErr     <= err_nxt;
      case (state)
        S_IDLE:  if (trig) word_cnt <= '0;
        S_RD:    lat_cnt <= '0;
        S_LAT:   lat_cnt <= lat_cnt + 2'd1;
        S_LOAD: begin
          shreg    <= iData;
          byte_cnt <= '0;
        end
        S_SEND: begin
          oData   <= shreg[7:0];
          shreg   <= shreg >> 8;
          grd_cnt <= '0;
        end
        S_GUARD: grd_cnt <= grd_cnt + 1'b1;
        S_WAITTX: begin
          if (!txBusy) begin
            if (byte_cnt < LAST_BYTE)      byte_cnt <= byte_cnt + 3'd1;
            else if (word_cnt < LAST_WORD) word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
